// File: rtl/dot_product_pkg.sv
// Shared types for the dot product front end.
//   N_LANES / ELEM_W : default vector geometry used by the slot type
//   LANE_W           : width of the lane index
//   CW               : width of the lane count (1..N)
//   vec_slot_t       : one buffered vector pair plus its lane count
//   occ_e            : buffer occupancy state
package dot_product_pkg;
  localparam int N_LANES = 4;
  localparam int ELEM_W  = 8;
  localparam int LANE_W  = $clog2(N_LANES);
  localparam int CW      = $clog2(N_LANES + 1);

  typedef struct packed {
    logic [ELEM_W*N_LANES-1:0] v1;
    logic [ELEM_W*N_LANES-1:0] v2;
    logic [CW-1:0]             cnt;
  } vec_slot_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;
endpackage

// File: rtl/dot_product_feeder.sv
// Serial-to-packed front end for the dot product datapath. Operand pairs
// arrive one per handshake and are packed into two N-lane vectors held in a
// two-slot FIFO, so one finished vector can wait downstream while the next is
// being assembled.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready   : input pair handshake
//   s_a, s_b          : elements for vector 1 / vector 2
//   s_last            : pair closes the current vector early
//   m_valid/m_ready   : output vector handshake
//   m_vec1, m_vec2    : packed vectors, lane i at [(i+1)*DW-1 : i*DW]
//   m_count           : number of real lanes, 1..N
module dot_product_feeder
  import dot_product_pkg::*;
#(
  parameter int N  = N_LANES,
  parameter int DW = ELEM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_a,
  input  logic [DW-1:0]     s_b,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW*N-1:0]   m_vec1,
  output logic [DW*N-1:0]   m_vec2,
  output logic [CW-1:0]     m_count
);

  occ_e              occ, occ_nxt;
  logic              wr_ptr, rd_ptr;
  logic [LANE_W-1:0] idx;
  vec_slot_t         slot [2];

  logic              accept, complete, pop;
  logic [DW*N-1:0]   lane_v1, lane_v2;

  assign s_ready  = (occ != TWO);
  assign m_valid  = (occ != EMPTY);
  assign accept   = s_valid & s_ready;
  assign complete = accept & (s_last | (idx == LANE_W'(N - 1)));
  assign pop      = m_valid & m_ready;

  // Next contents of the slot being filled: the addressed lane takes the new
  // pair; on completion every higher lane is cleared so an early-closed
  // vector never carries lanes from an older vector in the same slot.
  for (genvar g = 0; g < N; g++) begin : g_lane
    localparam logic [LANE_W-1:0] LANE = LANE_W'(g);
    logic sel, clr;
    assign sel = (idx == LANE);
    assign clr = complete & (LANE > idx);
    assign lane_v1[g*DW +: DW] = sel ? s_a : (clr ? '0 : slot[wr_ptr].v1[g*DW +: DW]);
    assign lane_v2[g*DW +: DW] = sel ? s_b : (clr ? '0 : slot[wr_ptr].v2[g*DW +: DW]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ     <= EMPTY;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      idx     <= '0;
      slot[0] <= '0;
      slot[1] <= '0;
    end else begin
      occ <= occ_nxt;
      if (accept) begin
        slot[wr_ptr].v1 <= lane_v1;
        slot[wr_ptr].v2 <= lane_v2;
      end
      if (complete) begin
        slot[wr_ptr].cnt <= CW'(idx) + CW'(1);
        idx              <= '0;
        wr_ptr           <= ~wr_ptr;
      end else if (accept) begin
        idx <= idx + LANE_W'(1);
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  // Occupancy: complete adds one, pop removes one, both together cancel.
  always_comb begin
    occ_nxt = occ;
    unique case (occ)
      EMPTY:   if (complete)         occ_nxt = ONE;
      ONE:     if (complete && !pop) occ_nxt = TWO;
               else if (pop && !complete) occ_nxt = EMPTY;
      TWO:     if (pop)              occ_nxt = ONE;
      default: occ_nxt = EMPTY;
    endcase
  end

  assign m_vec1  = m_valid ? slot[rd_ptr].v1  : '0;
  assign m_vec2  = m_valid ? slot[rd_ptr].v2  : '0;
  assign m_count = m_valid ? slot[rd_ptr].cnt : '0;

endmodule

// File: tb/tb_dot_product_feeder.sv
module tb_dot_product_feeder;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_a, s_b;
  logic          m_valid, m_ready;
  logic [31:0]   m_vec1, m_vec2;
  logic [2:0]    m_count;

  dot_product_feeder #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_vec1(m_vec1), .m_vec2(m_vec2), .m_count(m_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pairs of the vector under construction, and the queue
  // of finished vectors waiting downstream (buffer depth two).
  typedef struct { logic [31:0] v1; logic [31:0] v2; logic [2:0] cnt; } vec_t;
  logic [7:0] cur_a[$];
  logic [7:0] cur_b[$];
  vec_t       outq[$];

  typedef struct {
    logic [7:0]  a[4];
    logic [7:0]  b[4];
    int          len;
    logic        use_last;
    logic [31:0] exp_v1;
    logic [31:0] exp_v2;
    logic [2:0]  exp_cnt;
  } row_t;
  row_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("s_ready", s_ready, outq.size() < 2);
    chk("m_valid", m_valid, outq.size() != 0);
    if (outq.size() != 0) begin
      chk("m_vec1", m_vec1, outq[0].v1);
      chk("m_vec2", m_vec2, outq[0].v2);
      chk("m_count", m_count, outq[0].cnt);
    end else begin
      chk("m_vec1_idle", m_vec1, 0);
      chk("m_vec2_idle", m_vec2, 0);
      chk("m_count_idle", m_count, 0);
    end
  endtask

  task automatic predict(output logic acc);
    vec_t v;
    logic pop;
    pop = (outq.size() != 0) && m_ready;
    acc = s_valid && (outq.size() < 2);
    if (pop) void'(outq.pop_front());
    if (acc) begin
      cur_a.push_back(s_a);
      cur_b.push_back(s_b);
      if (s_last || cur_a.size() == N) begin
        v.v1 = '0; v.v2 = '0;
        for (int i = 0; i < cur_a.size(); i++) begin
          v.v1[i*8 +: 8] = cur_a[i];
          v.v2[i*8 +: 8] = cur_b[i];
        end
        v.cnt = 3'(cur_a.size());
        outq.push_back(v);
        cur_a.delete();
        cur_b.delete();
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic last, input logic mr, output logic acc);
    model_check();
    s_valid = v; s_a = a; s_b = b; s_last = last; m_ready = mr;
    predict(acc);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last, input logic mr);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) step(1'b1, a, b, last, mr, acc);
    if (!acc) chk("accept_timeout", acc, 1);
  endtask

  task automatic idle(input logic mr);
    logic acc;
    step(1'b0, 8'h00, 8'h00, 1'b0, mr, acc);
  endtask

  function automatic int dotp(input logic [31:0] x, input logic [31:0] y);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(x[i*8 +: 8]) * int'(y[i*8 +: 8]);
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic acc;
    tbl[0] = '{a:'{8'd1, 8'd2, 8'd3, 8'd4}, b:'{8'd5, 8'd6, 8'd7, 8'd8}, len:4, use_last:1'b1,
               exp_v1:32'h04030201, exp_v2:32'h08070605, exp_cnt:3'd4};
    tbl[1] = '{a:'{8'd9, 8'd10, 8'd0, 8'd0}, b:'{8'd2, 8'd3, 8'd0, 8'd0}, len:2, use_last:1'b1,
               exp_v1:32'h00000A09, exp_v2:32'h00000302, exp_cnt:3'd2};
    tbl[2] = '{a:'{8'hFF, 8'h80, 8'h7F, 8'h00}, b:'{8'h01, 8'h02, 8'h03, 8'h00}, len:3, use_last:1'b1,
               exp_v1:32'h007F80FF, exp_v2:32'h00030201, exp_cnt:3'd3};
    tbl[3] = '{a:'{8'h11, 8'h22, 8'h33, 8'h44}, b:'{8'hAA, 8'hBB, 8'hCC, 8'hDD}, len:4, use_last:1'b0,
               exp_v1:32'h44332211, exp_v2:32'hDDCCBBAA, exp_cnt:3'd4};
    tbl[4] = '{a:'{8'h05, 8'h00, 8'h00, 8'h00}, b:'{8'h06, 8'h00, 8'h00, 8'h00}, len:1, use_last:1'b1,
               exp_v1:32'h00000005, exp_v2:32'h00000006, exp_cnt:3'd1};

    // Reset state
    rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_vec1", m_vec1, 0);
    chk("rst_m_vec2", m_vec2, 0);
    chk("rst_m_count", m_count, 0);
    rst_n = 1'b1;
    idle(1'b1);

    // Table vectors: full, early close after full, odd values, close by count, single lane
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < tbl[r].len; j++)
        send(tbl[r].a[j], tbl[r].b[j], tbl[r].use_last && (j == tbl[r].len - 1), 1'b1);
      chk($sformatf("tbl%0d_valid", r), m_valid, 1);
      chk($sformatf("tbl%0d_vec1", r), m_vec1, tbl[r].exp_v1);
      chk($sformatf("tbl%0d_vec2", r), m_vec2, tbl[r].exp_v2);
      chk($sformatf("tbl%0d_count", r), m_count, tbl[r].exp_cnt);
      if (r == 0) chk("tbl0_dot", dotp(m_vec1, m_vec2), 70);
    end
    idle(1'b1);
    idle(1'b1);

    // Backpressure: two vectors fill the buffer, the ninth pair must stall
    for (int k = 0; k < 8; k++) send(8'(k + 1), 8'(k + 8'h21), 1'b0, 1'b0);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_vec1", m_vec1, 32'h04030201);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'd9, 8'h29, 1'b0, 1'b0, acc);
      chk("bp_no_accept", acc, 0);
    end
    chk("bp_hold_vec1", m_vec1, 32'h04030201);
    chk("bp_hold_vec2", m_vec2, 32'h24232221);
    for (int k = 8; k < 12; k++) send(8'(k + 1), 8'(k + 8'h21), 1'b0, 1'b1);
    for (int k = 0; k < 10 && outq.size() != 0; k++) idle(1'b1);
    chk("bp_drained", outq.size(), 0);

    // Complete and pop in the same cycle with occupancy ONE
    for (int k = 0; k < 4; k++) send(8'(8'h31 + k), 8'(8'h61 + k), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send(8'(8'h41 + k), 8'(8'h71 + k), 1'b0, 1'b0);
    send(8'h44, 8'h74, 1'b1, 1'b1);
    chk("sim_m_valid", m_valid, 1);
    chk("sim_s_ready", s_ready, 1);
    chk("sim_vec1", m_vec1, 32'h44434241);
    chk("sim_vec2", m_vec2, 32'h74737271);
    idle(1'b1);

    // Reset in the middle of a vector
    send(8'hE1, 8'hF1, 1'b0, 1'b1);
    send(8'hE2, 8'hF2, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    chk("mid_rst_vec1", m_vec1, 0);
    cur_a.delete(); cur_b.delete(); outq.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) send(8'(8'h51 + k), 8'(8'h81 + k), 1'b0, 1'b0);
    chk("post_rst_vec1", m_vec1, 32'h54535251);
    chk("post_rst_vec2", m_vec2, 32'h84838281);
    chk("post_rst_count", m_count, 4);
    idle(1'b1);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, acc);
    for (int k = 0; k < 10 && outq.size() != 0; k++) idle(1'b1);
    model_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
